mem_port_arbiter: RTL

//  Shares the single-port, word-aligned data RAM between two requesters:
//  M0 = CPU load/store unit and M1 = PIM weight/activation DMA engine.
//  The arbiter works per beat with round-robin between M0 and M1, and

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_resp.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data-RAM port arbiter.
// State encodings stay as plain constants so legacy tools can reuse them.
package mem_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_LOCK1 = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    LOCK1 = ST_LOCK1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam int         DEFAULT_MAX_BURST = 16;
  localparam logic [1:0] WORD_ALIGN_MASK   = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_resp.sv
// Per-master response register: captures RAM read data or an alignment
// error on the accepting edge and presents it for exactly one cycle.
module mem_arb_resp
  import mem_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          resp_i,
  input  logic          err_i,
  input  logic [DW-1:0] ram_q_i,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o
);

  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = resp_i;
    err_d    = resp_i & err_i;
    rdata_d  = rdata_q;
    if (resp_i) begin
      rdata_d = err_i ? '0 : ram_q_i;
    end
  end

  // Response stage: beat accepted at edge N is visible during cycle N+1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Per-beat round-robin arbiter between the CPU LSU (M0) and the PIM DMA (M1)
// for a single-port RAM, with a bounded M1 burst lock.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_last,
  output logic          m1_ready,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic [AW-1:0] ram_A,
  output logic [DW-1:0] ram_D,
  output logic          ram_WE,
  input  logic [DW-1:0] ram_Q
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  arb_state_e    state_q, state_d;
  owner_e        last_grant_q, last_grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  owner_e        grant;
  logic          yield_m0;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_aligned;
  logic          xfer0, xfer1;

  // Once M1 has used its burst allowance with M0 waiting, the lock cycle
  // grants nobody; the following IDLE cycle then picks M0 by round-robin.
  assign yield_m0 = (state_q == LOCK1) && (beat_cnt_q == CNT_MAX) && m0_req;

  always_comb begin
    grant = OWN_NONE;
    if (state_q == LOCK1) begin
      if (m1_req && !yield_m0) begin
        grant = OWN_M1;
      end
    end else if (m0_req && m1_req) begin
      grant = (last_grant_q == OWN_M0) ? OWN_M1 : OWN_M0;
    end else if (m0_req) begin
      grant = OWN_M0;
    end else if (m1_req) begin
      grant = OWN_M1;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (grant)
      OWN_M0: begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
      end
      OWN_M1: begin
        sel_we    = m1_we;
        sel_addr  = m1_addr;
        sel_wdata = m1_wdata;
      end
      default: begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
      end
    endcase
  end

  assign sel_aligned = is_word_aligned(sel_addr[1:0]);
  assign xfer0       = (grant == OWN_M0);
  assign xfer1       = (grant == OWN_M1);

  assign m0_ready = xfer0;
  assign m1_ready = xfer1;
  assign ram_A    = {sel_addr[AW-1:2], 2'b00};
  assign ram_D    = sel_wdata;
  assign ram_WE   = (grant != OWN_NONE) && sel_we && sel_aligned;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    last_grant_d = last_grant_q;
    if (grant != OWN_NONE) begin
      last_grant_d = grant;
    end
    case (state_q)
      IDLE: begin
        if (xfer1 && !m1_last) begin
          state_d    = LOCK1;
          beat_cnt_d = CW'(1);
        end
      end
      LOCK1: begin
        if (xfer1) begin
          if (beat_cnt_q != CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
          if (m1_last) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end
        end else begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Arbitration state stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_M1;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  mem_arb_resp #(.DW(DW)) u_resp_m0 (
    .clk_i    (CLK),
    .rst_i    (RST),
    .resp_i   (xfer0 && (!m0_we || !sel_aligned)),
    .err_i    (!sel_aligned),
    .ram_q_i  (ram_Q),
    .rvalid_o (m0_rvalid),
    .rdata_o  (m0_rdata),
    .err_o    (m0_err)
  );

  mem_arb_resp #(.DW(DW)) u_resp_m1 (
    .clk_i    (CLK),
    .rst_i    (RST),
    .resp_i   (xfer1 && (!m1_we || !sel_aligned)),
    .err_i    (!sel_aligned),
    .ram_q_i  (ram_Q),
    .rvalid_o (m1_rvalid),
    .rdata_o  (m1_rdata),
    .err_o    (m1_err)
  );

endmodule
